// File: rtl/nn_mac_pkg.sv
// nn_vec_mac shared types, defaults and requantizer.
// Imported by the lane and the top-level FSM.
package nn_mac_pkg;

  localparam int NN_DATA_WIDTH  = 8;
  localparam int NN_ACCUM_WIDTH = 32;
  localparam int NN_LANES       = 4;
  localparam int NN_FRAC_BITS   = 8;
  localparam int NN_MAX_LEN     = 1024;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN,
    OUTPUT
  } nn_vec_mac_state_t;

  typedef struct packed {
    logic signed [63:0] value;
    logic               sat;
  } nn_rq_t;

  // Round-half-up, arithmetic shift, optional ReLU, clip to data_width.
  // The 64-bit carrier leaves headroom for the rounding carry.
  function automatic nn_rq_t nn_requant(
    input logic signed [63:0] acc,
    input int                 frac_bits,
    input logic               relu_en,
    input int                 data_width
  );
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic signed [63:0] c;
    nn_rq_t             o;
    r = acc;
    if (frac_bits > 0)
      r = r + (64'sd1 <<< (frac_bits - 1));
    r = r >>> frac_bits;
    if (relu_en && (r < 0))
      r = '0;
    hi = (64'sd1 <<< (data_width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (data_width - 1));
    if (r > hi)
      c = hi;
    else if (r < lo)
      c = lo;
    else
      c = r;
    o.value = c;
    o.sat   = (c != r);
    return o;
  endfunction

endpackage

// File: rtl/nn_mac_lane.sv
// One dot-product lane: product register, accumulator,
// bias preload and output requantizer.
module nn_mac_lane
  import nn_mac_pkg::*;
#(
  parameter int DATA_WIDTH  = NN_DATA_WIDTH,
  parameter int ACCUM_WIDTH = NN_ACCUM_WIDTH,
  parameter int FRAC_BITS   = NN_FRAC_BITS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic                   bias_enable,
  input  logic [ACCUM_WIDTH-1:0] bias,
  input  logic                   beat,
  input  logic [DATA_WIDTH-1:0]  activation,
  input  logic [DATA_WIDTH-1:0]  weight,
  input  logic                   relu_en,
  input  logic                   out_valid,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic [ACCUM_WIDTH-1:0] out_accum,
  output logic                   out_sat
);

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic                           prod_vld;
  logic signed [ACCUM_WIDTH-1:0]  acc;
  nn_rq_t                         rq;
  logic                           unused_hi;

  // Stage 1 registers the product; stage 2 folds it into the accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      prod     <= '0;
      prod_vld <= 1'b0;
      acc      <= '0;
    end else begin
      prod_vld <= beat;
      if (beat)
        prod <= $signed(activation) * $signed(weight);
      if (load)
        acc <= bias_enable ? $signed(bias) : '0;
      else if (prod_vld)
        acc <= acc + ACCUM_WIDTH'(prod);
    end
  end

  // Requantize the settled accumulator; outputs read zero when idle.
  always_comb begin
    rq        = nn_requant(64'(acc), FRAC_BITS, relu_en, DATA_WIDTH);
    out_data  = out_valid ? rq.value[DATA_WIDTH-1:0] : '0;
    out_accum = out_valid ? acc : '0;
    out_sat   = out_valid & rq.sat;
  end

  assign unused_hi = ^rq.value[63:DATA_WIDTH];

endmodule

// File: rtl/nn_vec_mac.sv
// Multi-lane fixed-point dot-product engine.
// FSM, beat counter and handshakes; lanes do the arithmetic.
module nn_vec_mac
  import nn_mac_pkg::*;
#(
  parameter int DATA_WIDTH  = NN_DATA_WIDTH,
  parameter int ACCUM_WIDTH = NN_ACCUM_WIDTH,
  parameter int LANES       = NN_LANES,
  parameter int FRAC_BITS   = NN_FRAC_BITS,
  parameter int MAX_LEN     = NN_MAX_LEN,
  parameter int LEN_WIDTH   = $clog2(MAX_LEN + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [LEN_WIDTH-1:0]         len,
  input  logic                         bias_enable,
  input  logic                         relu_en,
  input  logic [LANES*ACCUM_WIDTH-1:0] bias,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_WIDTH-1:0]        activation,
  input  logic [LANES*DATA_WIDTH-1:0]  weight,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES*DATA_WIDTH-1:0]  out_data,
  output logic [LANES*ACCUM_WIDTH-1:0] out_accum,
  output logic [LANES-1:0]             out_sat,
  output logic                         busy
);

  nn_vec_mac_state_t    state;
  logic [LEN_WIDTH-1:0] cnt;
  logic                 relu_q;
  logic                 beat;
  logic                 load;

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == OUTPUT);
  assign busy      = (state != IDLE);
  assign beat      = in_valid & in_ready;
  assign load      = start & (state == IDLE);

  // Pass sequencing: load, count beats, drain the pipe, hold result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      relu_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            relu_q <= relu_en;
            cnt    <= len;
            state  <= (len == '0) ? OUTPUT : ACCUM;
          end
        end
        ACCUM: begin
          if (beat) begin
            cnt <= cnt - 1'b1;
            if (cnt == LEN_WIDTH'(1))
              state <= DRAIN;
          end
        end
        DRAIN:   state <= OUTPUT;
        OUTPUT:  if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    nn_mac_lane #(
      .DATA_WIDTH  (DATA_WIDTH),
      .ACCUM_WIDTH (ACCUM_WIDTH),
      .FRAC_BITS   (FRAC_BITS)
    ) u_lane (
      .clk         (clk),
      .rst         (rst),
      .load        (load),
      .bias_enable (bias_enable),
      .bias        (bias[i*ACCUM_WIDTH +: ACCUM_WIDTH]),
      .beat        (beat),
      .activation  (activation),
      .weight      (weight[i*DATA_WIDTH +: DATA_WIDTH]),
      .relu_en     (relu_q),
      .out_valid   (out_valid),
      .out_data    (out_data[i*DATA_WIDTH +: DATA_WIDTH]),
      .out_accum   (out_accum[i*ACCUM_WIDTH +: ACCUM_WIDTH]),
      .out_sat     (out_sat[i])
    );
  end

endmodule

// File: tb/tb_nn_vec_mac.sv
// Self-checking bench for nn_vec_mac.
// Random and directed passes against a plain arithmetic model.
module tb_nn_vec_mac;

  localparam int DW = 8;
  localparam int AW = 32;
  localparam int L  = 4;
  localparam int FB = 8;
  localparam int LW = $clog2(1024 + 1);

  logic            clk = 0;
  logic            rst;
  logic            start;
  logic [LW-1:0]   len_i;
  logic            bias_enable;
  logic            relu_en;
  logic [L*AW-1:0] bias_bus;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   activation;
  logic [L*DW-1:0] weight;
  logic            out_valid;
  logic            out_ready;
  logic [L*DW-1:0] out_data;
  logic [L*AW-1:0] out_accum;
  logic [L-1:0]    out_sat;
  logic            busy;

  int n_cmp = 0;
  int n_bad = 0;

  int fa;
  int fw   [L];
  int bias_v [L];

  nn_vec_mac dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .len         (len_i),
    .bias_enable (bias_enable),
    .relu_en     (relu_en),
    .bias        (bias_bus),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .activation  (activation),
    .weight      (weight),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_accum   (out_accum),
    .out_sat     (out_sat),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference requantizer: round half up, floor shift, ReLU, clip.
  function automatic void ref_q(input longint acc, input bit relu,
                                output longint q, output bit s);
    longint r;
    longint hi;
    longint lo;
    r  = acc + ((FB > 0) ? (longint'(1) <<< (FB - 1)) : 0);
    r  = r >>> FB;
    if (relu && r < 0) r = 0;
    hi = (longint'(1) <<< (DW - 1)) - 1;
    lo = -(longint'(1) <<< (DW - 1));
    q  = (r > hi) ? hi : (r < lo) ? lo : r;
    s  = (q != r);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_pass(input string nm, input int len, input bit ben,
                          input bit relu, input bit rnd, input bit gaps,
                          input int stall, input bit poke);
    longint          m [L];
    int              a;
    int              wv [L];
    longint          q;
    bit              s;
    logic [L*DW-1:0] sd;
    logic [L*AW-1:0] sa;
    logic [L-1:0]    ss;
    bit              st_ok;
    start       = 1;
    len_i       = LW'(len);
    bias_enable = ben;
    relu_en     = relu;
    for (int i = 0; i < L; i++) bias_bus[i*AW +: AW] = bias_v[i];
    tick();
    start       = 0;
    relu_en     = ~relu;
    bias_enable = ~ben;
    for (int i = 0; i < L; i++) m[i] = ben ? longint'(bias_v[i]) : 0;
    if (len > 0) begin
      chk({nm, ":rdy"}, in_ready, 1);
      for (int b = 0; b < len; b++) begin
        if (gaps) begin
          repeat ($urandom_range(0, 2)) begin
            in_valid = 0;
            tick();
          end
        end
        if (rnd) begin
          a = int'($urandom_range(0, 255)) - 128;
          for (int i = 0; i < L; i++) wv[i] = int'($urandom_range(0, 255)) - 128;
        end else begin
          a = fa;
          for (int i = 0; i < L; i++) wv[i] = fw[i];
        end
        activation = DW'(a);
        for (int i = 0; i < L; i++) weight[i*DW +: DW] = DW'(wv[i]);
        in_valid = 1;
        if (poke && b == 1) begin
          start = 1;
          len_i = LW'(3);
        end
        tick();
        start = 0;
        for (int i = 0; i < L; i++) m[i] += longint'(a) * wv[i];
      end
      in_valid   = 1;
      activation = DW'(99);
      chk({nm, ":drain_rdy"}, in_ready, 0);
      chk({nm, ":drain_ov"}, out_valid, 0);
      tick();
      in_valid = 0;
    end
    chk({nm, ":ov"}, out_valid, 1);
    sd = out_data;
    sa = out_accum;
    ss = out_sat;
    st_ok = 1;
    out_ready = 0;
    repeat (stall) begin
      in_valid = 1;
      start    = poke;
      tick();
      start    = 0;
      in_valid = 0;
      if (out_valid !== 1 || out_data !== sd || out_accum !== sa ||
          out_sat !== ss || in_ready !== 0)
        st_ok = 0;
    end
    if (stall > 0) chk({nm, ":stable"}, st_ok, 1);
    chk({nm, ":out_rdy"}, in_ready, 0);
    for (int i = 0; i < L; i++) begin
      ref_q(longint'(int'(m[i])), relu, q, s);
      chk($sformatf("%s:acc%0d", nm, i),
          longint'($signed(out_accum[i*AW +: AW])), longint'(int'(m[i])));
      chk($sformatf("%s:data%0d", nm, i),
          longint'($signed(out_data[i*DW +: DW])), q);
      chk($sformatf("%s:sat%0d", nm, i), out_sat[i], s);
    end
    out_ready = 1;
    start     = poke;
    len_i     = LW'(2);
    tick();
    out_ready = 0;
    start     = 0;
    chk({nm, ":done_ov"}, out_valid, 0);
    chk({nm, ":done_busy"}, busy, 0);
    chk({nm, ":done_data"}, out_data, 0);
  endtask

  initial begin
    rst = 1; start = 0; len_i = '0; bias_enable = 0; relu_en = 0;
    bias_bus = '0; in_valid = 0; activation = '0; weight = '0;
    out_ready = 0;
    for (int i = 0; i < L; i++) bias_v[i] = 0;
    repeat (2) tick();
    chk("rst:in_ready", in_ready, 0);
    chk("rst:out_valid", out_valid, 0);
    chk("rst:busy", busy, 0);
    chk("rst:out_data", out_data, 0);
    chk("rst:out_accum", out_accum, 0);
    chk("rst:out_sat", out_sat, 0);
    rst = 0;
    tick();

    fa = 16; fw = '{64, -64, 5, -7};
    run_pass("basic", 4, 0, 0, 0, 0, 0, 0);
    run_pass("stall", 4, 0, 0, 0, 1, 5, 0);

    fa = 127; fw = '{127, 127, 127, 127};
    run_pass("satp", 16, 0, 0, 0, 0, 0, 0);
    fa = -128;
    run_pass("satn", 16, 0, 0, 0, 0, 1, 0);
    run_pass("relu", 16, 0, 1, 0, 0, 0, 0);

    bias_v = '{384, 384, 384, 384};
    run_pass("b384", 0, 1, 0, 0, 0, 0, 0);
    bias_v = '{-384, -384, -384, -384};
    run_pass("bm384", 0, 1, 0, 0, 0, 2, 0);
    bias_v = '{127, 127, 127, 127};
    run_pass("b127", 0, 1, 0, 0, 0, 0, 0);

    start = 1; len_i = LW'(8); bias_enable = 0;
    tick();
    start = 0;
    activation = DW'(50);
    weight = {L{8'sd40}};
    in_valid = 1;
    repeat (2) tick();
    rst = 1;
    tick();
    rst = 0;
    in_valid = 0;
    chk("midrst:in_ready", in_ready, 0);
    chk("midrst:busy", busy, 0);
    chk("midrst:out_valid", out_valid, 0);
    fa = 2; fw = '{3, 3, 3, 3};
    for (int i = 0; i < L; i++) bias_v[i] = 0;
    run_pass("after_rst", 1, 0, 0, 0, 0, 0, 0);

    in_valid = 1;
    activation = DW'(100);
    weight = {L{8'sd100}};
    tick();
    in_valid = 0;
    chk("idle_valid:busy", busy, 0);
    fa = -3; fw = '{7, -9, 11, 0};
    run_pass("poke", 6, 0, 0, 0, 0, 2, 1);

    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < L; i++) bias_v[i] = int'($urandom());
      run_pass($sformatf("rnd%0d", k), int'($urandom_range(0, 20)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1,
               1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
